nios2_mult_unit: RTL

//  Parametrised pipelined integer multiplier for the Nios II M-stage. Replaces the

---
 rtl/nios2_mult_pkg.sv | 27 ++
 rtl/nios2_mult_pp.sv | 49 ++++
 rtl/nios2_mult_unit.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/nios2_mult_pkg.sv
// Shared types and helpers for the Nios II M-stage multiplier.
//
// mult_op_t encodes the multiply flavour carried alongside each operand pair:
//   OP_MUL    low word of the product (signedness irrelevant)
//   OP_MULXUU high word, both operands unsigned
//   OP_MULXSU high word, operand A signed, operand B unsigned
//   OP_MULXSS high word, both operands signed
package nios2_mult_pkg;

    typedef logic [1:0] mult_op_t;

    localparam mult_op_t OP_MUL    = 2'b00;
    localparam mult_op_t OP_MULXUU = 2'b01;
    localparam mult_op_t OP_MULXSU = 2'b10;
    localparam mult_op_t OP_MULXSS = 2'b11;

    // Operand A is treated as two's complement for the mixed and signed forms.
    function automatic logic op_signed_a(input mult_op_t op);
        return (op == OP_MULXSU) || (op == OP_MULXSS);
    endfunction

    // Operand B is only signed in the fully signed form.
    function automatic logic op_signed_b(input mult_op_t op);
        return (op == OP_MULXSS);
    endfunction

endpackage

// File: rtl/nios2_mult_pp.sv
// One registered partial-product multiplier.
//
// Multiplies two (H+1)-bit signed values and registers the (2H+2)-bit signed
// result. The extra bit lets the parent feed either zero-extended (unsigned)
// or sign-extended half operands through the same signed multiplier, so a
// plain '*' on signed operands is all that is needed to map onto a DSP block.
//
// Ports:
//   clk, reset  clock and asynchronous active-high reset
//   enable      load a new product this cycle, otherwise hold
//   a, b        signed half operands (H+1 bits)
//   p_q         registered signed product (2H+2 bits)
module nios2_mult_pp
    import nios2_mult_pkg::*;
#(
    parameter int H = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic signed [H:0]     a,
    input  logic signed [H:0]     b,
    output logic signed [2*H+1:0] p_q
);

    logic signed [2*H+1:0] a_x;
    logic signed [2*H+1:0] b_x;
    logic signed [2*H+1:0] p_d;

    // Widen both operands to the product width first so the multiply is
    // evaluated at full width with no truncation.
    always_comb begin
        a_x = {{(H+1){a[H]}}, a};
        b_x = {{(H+1){b[H]}}, b};
        p_d = p_q;
        if (enable) begin
            p_d = a_x * b_x;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            p_q <= '0;
        end else begin
            p_q <= p_d;
        end
    end

endmodule

// File: rtl/nios2_mult_unit.sv
// Pipelined integer multiplier for the Nios II M-stage.
//
// Stage 1 registers four half-width partial products, stage 2 sums them into
// the full 2*DATA_W product and selects the low or high word, and PIPE_EXT
// further stages simply delay the result. Latency is 2 + PIPE_EXT cycles.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. in_ready = advance & !flush, where advance = !out_valid |
// out_ready; the whole pipe shifts together on advance and holds otherwise,
// so out_result/out_tag stay stable while out_valid=1 and out_ready=0.
// flush clears every valid bit on the next edge (data registers hold) and
// blocks acceptance in the same cycle.
//
// Ports:
//   clk, reset            clock and asynchronous active-high reset
//   flush                 synchronous pipeline kill
//   in_valid / in_ready   input handshake
//   in_op                 mult_op_t mode
//   in_src1, in_src2      operands A and B (DATA_W)
//   in_tag                sideband tag carried to out_tag
//   out_valid / out_ready output handshake
//   out_result            selected product word (DATA_W)
//   out_tag               tag of the result
module nios2_mult_unit
    import nios2_mult_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int PIPE_EXT = 0,
    parameter int TAG_W    = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  mult_op_t          in_op,
    input  logic [DATA_W-1:0] in_src1,
    input  logic [DATA_W-1:0] in_src2,
    input  logic [TAG_W-1:0]  in_tag,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_result,
    output logic [TAG_W-1:0]  out_tag
);

    localparam int H      = DATA_W / 2;
    localparam int PP_W   = DATA_W + 2;
    localparam int PROD_W = 2 * DATA_W;

    logic advance;
    logic data_en;

    assign advance  = !out_valid || out_ready;
    assign in_ready = advance && !flush;
    // Data registers only move on an un-flushed advance; a flush leaves them as-is.
    assign data_en  = advance && !flush;

    // ------------------------------------------------------------------
    // Stage 1: half operands and partial products
    // ------------------------------------------------------------------
    logic              sign_a;
    logic              sign_b;
    logic signed [H:0] a_lo_x;
    logic signed [H:0] a_hi_x;
    logic signed [H:0] b_lo_x;
    logic signed [H:0] b_hi_x;

    // Lower halves are always magnitudes; only the upper halves carry sign.
    always_comb begin
        sign_a = op_signed_a(in_op);
        sign_b = op_signed_b(in_op);
        a_lo_x = {1'b0, in_src1[H-1:0]};
        a_hi_x = {sign_a & in_src1[DATA_W-1], in_src1[DATA_W-1:H]};
        b_lo_x = {1'b0, in_src2[H-1:0]};
        b_hi_x = {sign_b & in_src2[DATA_W-1], in_src2[DATA_W-1:H]};
    end

    logic signed [PP_W-1:0] pp_ll;
    logic signed [PP_W-1:0] pp_lh;
    logic signed [PP_W-1:0] pp_hl;
    logic signed [PP_W-1:0] pp_hh;

    nios2_mult_pp #(.H(H)) u_pp_ll (
        .clk(clk), .reset(reset), .enable(data_en), .a(a_lo_x), .b(b_lo_x), .p_q(pp_ll)
    );
    nios2_mult_pp #(.H(H)) u_pp_lh (
        .clk(clk), .reset(reset), .enable(data_en), .a(a_lo_x), .b(b_hi_x), .p_q(pp_lh)
    );
    nios2_mult_pp #(.H(H)) u_pp_hl (
        .clk(clk), .reset(reset), .enable(data_en), .a(a_hi_x), .b(b_lo_x), .p_q(pp_hl)
    );
    nios2_mult_pp #(.H(H)) u_pp_hh (
        .clk(clk), .reset(reset), .enable(data_en), .a(a_hi_x), .b(b_hi_x), .p_q(pp_hh)
    );

    logic             v1_q, v1_d;
    mult_op_t         op1_q, op1_d;
    logic [TAG_W-1:0] tag1_q, tag1_d;

    always_comb begin
        v1_d   = v1_q;
        op1_d  = op1_q;
        tag1_d = tag1_q;
        if (flush) begin
            v1_d = 1'b0;
        end else if (advance) begin
            // in_ready is high here, so in_valid alone means accept.
            v1_d = in_valid;
        end
        if (data_en) begin
            op1_d  = in_op;
            tag1_d = in_tag;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            v1_q   <= 1'b0;
            op1_q  <= OP_MUL;
            tag1_q <= '0;
        end else begin
            v1_q   <= v1_d;
            op1_q  <= op1_d;
            tag1_q <= tag1_d;
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: partial-product sum and word select
    // ------------------------------------------------------------------
    logic [PROD_W-1:0] ll_x, lh_x, hl_x, hh_x;
    logic [PROD_W-1:0] product;
    logic [DATA_W-1:0] sel_word;

    // Sign-extend each partial product, then sum modulo 2^PROD_W; the wrap
    // is harmless because the true product always fits in PROD_W bits.
    always_comb begin
        ll_x     = {{(PROD_W-PP_W){pp_ll[PP_W-1]}}, pp_ll};
        lh_x     = {{(PROD_W-PP_W){pp_lh[PP_W-1]}}, pp_lh};
        hl_x     = {{(PROD_W-PP_W){pp_hl[PP_W-1]}}, pp_hl};
        hh_x     = {{(PROD_W-PP_W){pp_hh[PP_W-1]}}, pp_hh};
        product  = ll_x + (lh_x << H) + (hl_x << H) + (hh_x << (2*H));
        sel_word = (op1_q == OP_MUL) ? product[DATA_W-1:0] : product[PROD_W-1:DATA_W];
    end

    logic              v2_q, v2_d;
    logic [DATA_W-1:0] res2_q, res2_d;
    logic [TAG_W-1:0]  tag2_q, tag2_d;

    always_comb begin
        v2_d   = v2_q;
        res2_d = res2_q;
        tag2_d = tag2_q;
        if (flush) begin
            v2_d = 1'b0;
        end else if (advance) begin
            v2_d = v1_q;
        end
        if (data_en) begin
            res2_d = sel_word;
            tag2_d = tag1_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            v2_q   <= 1'b0;
            res2_q <= '0;
            tag2_q <= '0;
        end else begin
            v2_q   <= v2_d;
            res2_q <= res2_d;
            tag2_q <= tag2_d;
        end
    end

    // ------------------------------------------------------------------
    // Stages 3..S: delay line; element 0 is the stage-2 register.
    // ------------------------------------------------------------------
    logic              dly_v   [0:PIPE_EXT];
    logic [DATA_W-1:0] dly_res [0:PIPE_EXT];
    logic [TAG_W-1:0]  dly_tag [0:PIPE_EXT];

    assign dly_v[0]   = v2_q;
    assign dly_res[0] = res2_q;
    assign dly_tag[0] = tag2_q;

    for (genvar g = 1; g <= PIPE_EXT; g++) begin : g_ext
        logic              v_q, v_d;
        logic [DATA_W-1:0] res_q, res_d;
        logic [TAG_W-1:0]  tag_q, tag_d;

        always_comb begin
            v_d   = v_q;
            res_d = res_q;
            tag_d = tag_q;
            if (flush) begin
                v_d = 1'b0;
            end else if (advance) begin
                v_d = dly_v[g-1];
            end
            if (data_en) begin
                res_d = dly_res[g-1];
                tag_d = dly_tag[g-1];
            end
        end

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                v_q   <= 1'b0;
                res_q <= '0;
                tag_q <= '0;
            end else begin
                v_q   <= v_d;
                res_q <= res_d;
                tag_q <= tag_d;
            end
        end

        assign dly_v[g]   = v_q;
        assign dly_res[g] = res_q;
        assign dly_tag[g] = tag_q;
    end

    assign out_valid  = dly_v[PIPE_EXT];
    assign out_result = dly_res[PIPE_EXT];
    assign out_tag    = dly_tag[PIPE_EXT];

endmodule
